// File: rtl/register_file_write_arbiter.sv
// Write-port owner for register_file: zero-sweeps x1..x(N-1) after reset, then arbitrates
// ALU and load writebacks with fixed ALU priority and a starvation override for loads.
module register_file_write_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Alu_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Alu_Addr,
   input  logic [XLEN-1:0]           i_Alu_Data,
   output logic                      o_Alu_Ready,
   input  logic                      i_Load_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Load_Addr,
   input  logic [XLEN-1:0]           i_Load_Data,
   output logic                      o_Load_Ready,
   output logic                      o_Rf_Enable,
   output logic                      o_Rf_Write_Enable,
   output logic [REG_ADDR_WIDTH-1:0] o_Rf_Write_Addr,
   output logic [XLEN-1:0]           o_Rf_Write_Data,
   output logic                      o_Init_Done
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                    state;
   logic [REG_ADDR_WIDTH-1:0] sweep_cnt;
   logic [STARVE_W-1:0]       starve_cnt;
   logic                      load_priority;
   logic                      alu_accept;
   logic                      load_accept;
   logic [REG_ADDR_WIDTH-1:0] win_addr;
   logic [XLEN-1:0]           win_data;

   assign load_priority = (starve_cnt == STARVE_W'(STARVE_LIMIT));

   // Grant logic: readies depend only on state, starvation and the other requester's valid.
   always_comb begin
      o_Alu_Ready  = 1'b0;
      o_Load_Ready = 1'b0;
      if (!i_Reset && state == RUN) begin
         if (load_priority) begin
            o_Load_Ready = 1'b1;
            o_Alu_Ready  = ~i_Load_Valid;
         end else begin
            o_Alu_Ready  = 1'b1;
            o_Load_Ready = ~i_Alu_Valid;
         end
      end
   end

   assign alu_accept  = i_Alu_Valid & o_Alu_Ready;
   assign load_accept = i_Load_Valid & o_Load_Ready;
   assign win_addr    = alu_accept ? i_Alu_Addr : i_Load_Addr;
   assign win_data    = alu_accept ? i_Alu_Data : i_Load_Data;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state             <= INIT;
         sweep_cnt         <= REG_ADDR_WIDTH'(1);
         starve_cnt        <= '0;
         o_Rf_Enable       <= 1'b0;
         o_Rf_Write_Enable <= 1'b0;
         o_Rf_Write_Addr   <= '0;
         o_Rf_Write_Data   <= '0;
         o_Init_Done       <= 1'b0;
      end else begin
         o_Rf_Enable <= 1'b1;
         if (state == INIT) begin
            starve_cnt <= '0;
            // Counter wraps to zero after the last register has been put on the port.
            if (sweep_cnt == '0) begin
               state             <= RUN;
               o_Init_Done       <= 1'b1;
               o_Rf_Write_Enable <= 1'b0;
            end else begin
               o_Rf_Write_Enable <= 1'b1;
               o_Rf_Write_Addr   <= sweep_cnt;
               o_Rf_Write_Data   <= '0;
               sweep_cnt         <= sweep_cnt + REG_ADDR_WIDTH'(1);
            end
         end else begin
            // Writes to x0 are consumed without touching the port.
            if ((alu_accept || load_accept) && win_addr != '0) begin
               o_Rf_Write_Enable <= 1'b1;
               o_Rf_Write_Addr   <= win_addr;
               o_Rf_Write_Data   <= win_data;
            end else begin
               o_Rf_Write_Enable <= 1'b0;
            end

            if (i_Load_Valid && !load_accept) begin
               if (!load_priority)
                  starve_cnt <= starve_cnt + STARVE_W'(1);
            end else begin
               starve_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Scoreboard bench: driver models arbitration from the rules and queues expected port state;
// a monitor pops and compares after each edge. A shadow register file tracks committed writes.
module tb_register_file_write_arbiter;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NREG  = 32;
   localparam int unsigned LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alu_valid = 1'b0, load_valid = 1'b0;
   logic [AW-1:0]   alu_addr = '0, load_addr = '0;
   logic [XLEN-1:0] alu_data = '0, load_data = '0;
   logic            alu_ready, load_ready;
   logic            rf_en, rf_we, init_done;
   logic [AW-1:0]   rf_addr;
   logic [XLEN-1:0] rf_data;

   register_file_write_arbiter #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .i_Clock(clk), .i_Reset(rst),
      .i_Alu_Valid(alu_valid), .i_Alu_Addr(alu_addr), .i_Alu_Data(alu_data), .o_Alu_Ready(alu_ready),
      .i_Load_Valid(load_valid), .i_Load_Addr(load_addr), .i_Load_Data(load_data), .o_Load_Ready(load_ready),
      .o_Rf_Enable(rf_en), .o_Rf_Write_Enable(rf_we), .o_Rf_Write_Addr(rf_addr),
      .o_Rf_Write_Data(rf_data), .o_Init_Done(init_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            en;
      logic            we;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            done;
   } port_t;

   port_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   // Reference model state
   bit              m_run;
   int              m_sweep;
   int              m_losses;
   logic [AW-1:0]   m_addr;
   logic [XLEN-1:0] m_data;
   logic [XLEN-1:0] m_rf [NREG];

   // Shadow register file: commits whatever the port presents at each edge; x0 stays 0.
   logic [XLEN-1:0] tb_rf [NREG];
   always @(posedge clk)
      if (rf_en && rf_we && rf_addr != '0) tb_rf[rf_addr] <= rf_data;

   // Monitor: compare the port one step after each edge against the queued expectation.
   always @(posedge clk) begin
      port_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rf_en !== e.en || rf_we !== e.we || init_done !== e.done ||
             (e.we && (rf_addr !== e.addr || rf_data !== e.data)) ||
             (!e.we && e.done && (rf_addr !== e.addr || rf_data !== e.data))) begin
            errors++;
            $display("FAIL port @%0t: got en=%b we=%b addr=%0d data=%h done=%b, want en=%b we=%b addr=%0d data=%h done=%b",
                     $time, rf_en, rf_we, rf_addr, rf_data, init_done, e.en, e.we, e.addr, e.data, e.done);
         end
      end
   end

   // Apply one cycle of stimulus, check readies, push the port state expected after the edge.
   task automatic drive(input bit r, input bit av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                        input bit lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld);
      bit    ar, lr, acc_a, acc_l;
      port_t e;
      @(negedge clk);
      rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
      load_valid = lv; load_addr = la; load_data = ld;
      #1;
      ar = 0; lr = 0;
      if (!r && m_run) begin
         if (m_losses >= LIMIT) begin lr = 1; ar = !lv; end
         else                   begin ar = 1; lr = !av; end
      end
      checks++;
      if (alu_ready !== ar || load_ready !== lr) begin
         errors++;
         $display("FAIL ready @%0t: got alu=%b load=%b, want alu=%b load=%b",
                  $time, alu_ready, load_ready, ar, lr);
      end
      e = '0;
      if (r) begin
         m_run = 0; m_sweep = 1; m_losses = 0; m_addr = '0; m_data = '0;
      end else begin
         e.en = 1;
         if (!m_run) begin
            m_losses = 0;
            if (m_sweep < NREG) begin
               e.we = 1; m_addr = AW'(m_sweep); m_data = '0;
               m_rf[m_sweep] = '0;
               m_sweep++;
            end else begin
               m_run = 1;
            end
         end else begin
            acc_a = av && ar;
            acc_l = lv && lr;
            if (acc_a && aa != 0) begin
               e.we = 1; m_addr = aa; m_data = ad; m_rf[aa] = ad;
            end else if (acc_l && la != 0) begin
               e.we = 1; m_addr = la; m_data = ld; m_rf[la] = ld;
            end
            if (lv && !acc_l) m_losses = (m_losses < LIMIT) ? m_losses + 1 : LIMIT;
            else              m_losses = 0;
         end
         e.done = m_run;
      end
      e.addr = m_addr; e.data = m_data;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, '0, '0);
   endtask

   task automatic check_rf(input int a, input logic [XLEN-1:0] want);
      checks++;
      if (tb_rf[a] !== want) begin
         errors++;
         $display("FAIL rf_x%0d: got %h, want %h", a, tb_rf[a], want);
      end
   endtask

   initial begin
      bit              av, lv;
      logic [AW-1:0]   aa, la;
      for (int i = 0; i < NREG; i++) begin
         tb_rf[i] = (i == 0) ? '0 : (32'hBAD0_0000 | XLEN'(i));
         m_rf[i]  = tb_rf[i];
      end
      m_run = 0; m_sweep = 1; m_losses = 0; m_addr = '0; m_data = '0;

      // Reset, then the zero sweep (31 writes) and the move to RUN
      drive(1, 0, '0, '0, 0, '0, '0);
      drive(1, 0, '0, '0, 0, '0, '0);
      idle(34);
      check_rf(5, '0);

      // Lone ALU write
      drive(0, 1, AW'(3), 32'hDEAD_BEEF, 0, '0, '0);
      idle(2);
      check_rf(3, 32'hDEAD_BEEF);

      // Both valid continuously: 4:1 ALU/load pattern via ready checks
      for (int i = 0; i < 12; i++)
         drive(0, 1, AW'(10 + i % 4), XLEN'(32'hA000 + i), 1, AW'(20 + i % 4), XLEN'(32'hB000 + i));
      idle(2);

      // Load to x0 is consumed without a port write
      drive(0, 0, '0, '0, 1, '0, 32'h1234);
      idle(2);
      check_rf(0, '0);

      // Reset one cycle after an ALU accept to x7; sweep clears it again
      drive(0, 1, AW'(7), 32'h55, 0, '0, '0);
      drive(1, 0, '0, '0, 0, '0, '0);
      idle(34);
      check_rf(7, '0);

      // Same-address race: ALU wins first, load lands later
      drive(0, 1, AW'(9), 32'h11, 1, AW'(9), 32'h22);
      drive(0, 0, '0, '0, 1, AW'(9), 32'h22);
      idle(1);
      check_rf(9, 32'h11);
      idle(1);
      check_rf(9, 32'h22);

      // Randomized traffic with one mid-run reset
      for (int n = 0; n < 400; n++) begin
         av = ($urandom_range(0, 99) < 65);
         lv = ($urandom_range(0, 99) < 65);
         aa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         la = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         drive((n == 200 || n == 201), av, aa, XLEN'($urandom), lv, la, XLEN'($urandom));
      end
      idle(3);
      for (int i = 0; i < NREG; i++) check_rf(i, m_rf[i]);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
